// File: rtl/xor_crc_pkg.sv
// Shared state encodings and CRC-8 defaults for the serial CRC engine.
package xor_crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] CRC8_POLY   = 8'h07;
   localparam logic [7:0] CRC8_INIT   = 8'h00;
   localparam logic [7:0] CRC8_XOROUT = 8'h00;

endpackage

// File: rtl/xor_crc_step.sv
// Combinational single-bit CRC update, MSB-first, implicit x^WIDTH term.
module xor_crc_step #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 8'h07
) (
   input  logic [WIDTH-1:0] crc_in,
   input  logic             bit_in,
   output logic [WIDTH-1:0] crc_out
);

   logic fb;

   assign fb = crc_in[WIDTH-1] ^ bit_in;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign crc_out[gi] = fb & POLY[gi];
         end else begin : g_upper
            assign crc_out[gi] = crc_in[gi-1] ^ (fb & POLY[gi]);
         end
      end
   endgenerate

endmodule

// File: rtl/xor_crc_serial.sv
// Serial CRC engine with frame bit count and valid/ready result hold.
// Define XOR_CRC_CHECK_EN to add the crc_ok residue-check output.
module xor_crc_serial
   import xor_crc_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] POLY   = WIDTH'(CRC8_POLY),
   parameter logic [WIDTH-1:0] INIT   = WIDTH'(CRC8_INIT),
   parameter logic [WIDTH-1:0] XOROUT = WIDTH'(CRC8_XOROUT),
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef XOR_CRC_CHECK_EN
   output logic             crc_ok,
`endif
   output logic [WIDTH-1:0] out_crc,
   output logic [CNT_W-1:0] out_len
);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   crc_reg, crc_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               in_ready_reg, in_ready_next;
   logic               out_valid_reg, out_valid_next;
   logic [WIDTH-1:0]   out_crc_reg, out_crc_next;
   logic [CNT_W-1:0]   out_len_reg, out_len_next;
`ifdef XOR_CRC_CHECK_EN
   logic               crc_ok_reg, crc_ok_next;
`endif

   logic               beat;
   logic [WIDTH-1:0]   crc_step;
   logic [CNT_W-1:0]   cnt_inc;

   xor_crc_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .crc_in  (crc_reg),
      .bit_in  (in_bit),
      .crc_out (crc_step)
   );

   assign beat    = in_valid & in_ready_reg;
   // Counter sticks at all-ones rather than wrapping on very long frames.
   assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next     = state_reg;
      crc_next       = crc_reg;
      cnt_next       = cnt_reg;
      in_ready_next  = in_ready_reg;
      out_valid_next = out_valid_reg;
      out_crc_next   = out_crc_reg;
      out_len_next   = out_len_reg;
`ifdef XOR_CRC_CHECK_EN
      crc_ok_next    = crc_ok_reg;
`endif
      case (state_reg)
         ST_IDLE, ST_BUSY: begin
            if (beat) begin
               crc_next = crc_step;
               cnt_next = cnt_inc;
               if (in_last) begin
                  state_next     = ST_DONE;
                  in_ready_next  = 1'b0;
                  out_valid_next = 1'b1;
                  out_crc_next   = crc_step ^ XOROUT;
                  out_len_next   = cnt_inc;
`ifdef XOR_CRC_CHECK_EN
                  crc_ok_next    = (crc_step == '0);
`endif
               end else begin
                  state_next = ST_BUSY;
               end
            end
         end
         ST_DONE: begin
            // in_ready stays low through the handshake cycle: one bubble per frame.
            if (out_ready) begin
               state_next     = ST_IDLE;
               crc_next       = INIT;
               cnt_next       = '0;
               in_ready_next  = 1'b1;
               out_valid_next = 1'b0;
            end
         end
         default: begin
            state_next     = ST_IDLE;
            crc_next       = INIT;
            cnt_next       = '0;
            in_ready_next  = 1'b1;
            out_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         crc_reg       <= INIT;
         cnt_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_crc_reg   <= '0;
         out_len_reg   <= '0;
`ifdef XOR_CRC_CHECK_EN
         crc_ok_reg    <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         crc_reg       <= crc_next;
         cnt_reg       <= cnt_next;
         in_ready_reg  <= in_ready_next;
         out_valid_reg <= out_valid_next;
         out_crc_reg   <= out_crc_next;
         out_len_reg   <= out_len_next;
`ifdef XOR_CRC_CHECK_EN
         crc_ok_reg    <= crc_ok_next;
`endif
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_crc   = out_crc_reg;
   assign out_len   = out_len_reg;
`ifdef XOR_CRC_CHECK_EN
   assign crc_ok    = crc_ok_reg;
`endif

endmodule

// File: tb/tb_xor_crc_serial.sv
// Directed bench for xor_crc_serial: known CRC-8 vectors, gaps, backpressure, reset.
module tb_xor_crc_serial;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_bit;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_crc;
   logic [15:0] out_len;
`ifdef XOR_CRC_CHECK_EN
   logic        crc_ok;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] msg [0:8];

   xor_crc_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef XOR_CRC_CHECK_EN
      .crc_ok    (crc_ok),
`endif
      .out_crc   (out_crc),
      .out_len   (out_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted beat; waits (bounded) for in_ready first.
   task automatic beat(input logic b, input logic l, input bit gap);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_bit   = b;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_bit   = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last, input bit gap, input int nbits);
      for (int i = 0; i < nbits; i++)
         beat(b[7-i], last && (i == 7), gap);
   endtask

   task automatic send_msg();
      for (int k = 0; k < 9; k++)
         send_byte(msg[k], k == 8, 1'b0, 8);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [7:0] held_crc;

   initial begin
      msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33;
      msg[3] = 8'h34; msg[4] = 8'h35; msg[5] = 8'h36;
      msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
      rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_crc",   {24'd0, out_crc}, 32'd0);
      chk("rst_out_len",   {16'd0, out_len}, 32'd0);

      // "123456789" back to back
      send_msg();
      chk("msg_latency",   {31'd0, out_valid}, 32'd1);
      chk("msg_crc",       {24'd0, out_crc}, 32'hF4);
      chk("msg_len",       {16'd0, out_len}, 32'd72);
      chk("msg_in_ready",  {31'd0, in_ready}, 32'd0);
      accept();
      chk("ack_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ack_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("retain_crc",    {24'd0, out_crc}, 32'hF4);
      chk("retain_len",    {16'd0, out_len}, 32'd72);

      // Single byte with a gap after every beat
      send_byte(8'h31, 1'b1, 1'b1, 8);
      chk("gap_valid",     {31'd0, out_valid}, 32'd1);
      chk("gap_crc",       {24'd0, out_crc}, 32'h97);
      chk("gap_len",       {16'd0, out_len}, 32'd8);

      // Backpressure: valid bits offered while the result is held
      held_crc = out_crc;
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid",    {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_crc",      {24'd0, out_crc}, {24'd0, held_crc});
         chk("bp_len",      {16'd0, out_len}, 32'd8);
      end
      in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0;
      accept();
      chk("bp_release",    {31'd0, out_valid}, 32'd0);
      send_byte(8'h31, 1'b1, 1'b0, 8);
      chk("bp_next_crc",   {24'd0, out_crc}, 32'h97);
      chk("bp_next_len",   {16'd0, out_len}, 32'd8);
      accept();

      // 1-bit frame
      beat(1'b1, 1'b1, 1'b0);
      chk("one_valid",     {31'd0, out_valid}, 32'd1);
      chk("one_crc",       {24'd0, out_crc}, 32'h07);
      chk("one_len",       {16'd0, out_len}, 32'd1);
      accept();

      // Reset in the middle of a frame (after 20 bits)
      send_byte(msg[0], 1'b0, 1'b0, 8);
      send_byte(msg[1], 1'b0, 1'b0, 8);
      send_byte(msg[2], 1'b0, 1'b0, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_out_crc",   {24'd0, out_crc}, 32'd0);
      chk("mrst_out_len",   {16'd0, out_len}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send_msg();
      chk("mrst_msg_crc",  {24'd0, out_crc}, 32'hF4);
      chk("mrst_msg_len",  {16'd0, out_len}, 32'd72);
      accept();

`ifdef XOR_CRC_CHECK_EN
      // Frame with its own CRC appended leaves a zero residue
      send_byte(8'h31, 1'b0, 1'b0, 8);
      send_byte(8'h97, 1'b1, 1'b0, 8);
      chk("chk_ok",        {31'd0, crc_ok}, 32'd1);
      chk("chk_crc",       {24'd0, out_crc}, 32'h00);
      chk("chk_len",       {16'd0, out_len}, 32'd16);
      accept();
      send_byte(8'h33, 1'b0, 1'b0, 8);
      send_byte(8'h97, 1'b1, 1'b0, 8);
      chk("chk_flip_ok",   {31'd0, crc_ok}, 32'd0);
      accept();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
